// File: rtl/packet_gen_prog.sv
// Programmable AXI-Stream test-packet generator: per-packet lengths from a writable table,
// finite or continuous runs, inter-packet gap, counter data pattern and graceful stop.
module packet_gen_prog #(
  parameter int unsigned DW      = 128,
  parameter int unsigned NUM_LEN = 8,
  parameter int unsigned LEN_W   = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       stop,
  input  logic [31:0]                num_packets,
  input  logic [7:0]                 gap_cycles,
  input  logic                       pattern_mode,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_LEN)-1:0] cfg_addr,
  input  logic [LEN_W-1:0]           cfg_len,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                pkt_count,
  output logic [DW-1:0]              axis_out_tdata,
  output logic [DW/8-1:0]            axis_out_tkeep,
  output logic                       axis_out_tlast,
  output logic                       axis_out_tvalid,
  input  logic                       axis_out_tready
);

  localparam int unsigned DB = DW / 8;
  localparam int unsigned AW = $clog2(NUM_LEN);
  localparam int unsigned PW = $clog2(DB);
  localparam logic [LEN_W-1:0] DbW = LEN_W'(DB);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pkt_count_q, pkt_count_d;
  logic [31:0]      num_q, num_d;
  logic [7:0]       gap_q, gap_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic             mode_q, mode_d;
  logic             stop_seen_q, stop_seen_d;
  logic             done_q, done_d;
  logic [15:0]      data_q, data_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] beats_q, beats_d;
  logic [PW-1:0]    part_q, part_d;
  logic [LEN_W-1:0] len_tab_q [NUM_LEN];
  logic [LEN_W-1:0] len_tab_d [NUM_LEN];

  logic             lat_en;
  logic [AW-1:0]    lat_idx;
  logic [LEN_W-1:0] lat_len;
  logic             hs;
  logic             last_beat;

  assign last_beat = (beat_q == beats_q);
  assign hs        = (state_q == StSend) && axis_out_tready;
  // Reads the registered table, so a write landing in the latch cycle is not seen yet.
  assign lat_len   = (len_tab_q[lat_idx] == '0) ? LEN_W'(1) : len_tab_q[lat_idx];

  always_comb begin
    state_d     = state_q;
    pkt_count_d = pkt_count_q;
    num_d       = num_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    mode_d      = mode_q;
    stop_seen_d = stop_seen_q;
    done_d      = 1'b0;
    data_d      = data_q;
    idx_d       = idx_q;
    beat_d      = beat_q;
    beats_d     = beats_q;
    part_d      = part_q;
    len_tab_d   = len_tab_q;
    lat_en      = 1'b0;
    lat_idx     = idx_q;

    if (cfg_we) len_tab_d[cfg_addr] = cfg_len;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_d       = num_packets;
          gap_d       = gap_cycles;
          mode_d      = pattern_mode;
          pkt_count_d = '0;
          idx_d       = '0;
          data_d      = 16'd1;
          stop_seen_d = stop;
          lat_en      = 1'b1;
          lat_idx     = '0;
          state_d     = StSend;
        end
      end
      StSend: begin
        stop_seen_d = stop_seen_q | stop;
        if (hs) begin
          data_d = data_q + 16'd1;
          beat_d = beat_q + LEN_W'(1);
          if (last_beat) begin
            pkt_count_d = pkt_count_q + 32'd1;
            idx_d       = idx_q + AW'(1);
            if (stop_seen_q || stop || (num_q != '0 && pkt_count_d == num_q)) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else if (gap_q != '0) begin
              gap_cnt_d = gap_q;
              state_d   = StGap;
            end else begin
              stop_seen_d = 1'b0;
              lat_en      = 1'b1;
              lat_idx     = idx_d;
            end
          end
        end
      end
      StGap: begin
        if (stop) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (gap_cnt_q == 8'd1) begin
          stop_seen_d = 1'b0;
          lat_en      = 1'b1;
          state_d     = StSend;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (lat_en) begin
      beat_d  = LEN_W'(1);
      beats_d = (lat_len - LEN_W'(1)) / DbW + LEN_W'(1);
      part_d  = PW'(lat_len % DbW);
      if (mode_q) data_d = 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      pkt_count_q <= '0;
      num_q       <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      mode_q      <= 1'b0;
      stop_seen_q <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= 16'd1;
      idx_q       <= '0;
      beat_q      <= LEN_W'(1);
      beats_q     <= LEN_W'(1);
      part_q      <= '0;
      for (int i = 0; i < NUM_LEN; i++) len_tab_q[i] <= DbW;
    end else begin
      state_q     <= state_d;
      pkt_count_q <= pkt_count_d;
      num_q       <= num_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      mode_q      <= mode_d;
      stop_seen_q <= stop_seen_d;
      done_q      <= done_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      beat_q      <= beat_d;
      beats_q     <= beats_d;
      part_q      <= part_d;
      len_tab_q   <= len_tab_d;
    end
  end

  always_comb begin
    axis_out_tkeep = '1;
    if (last_beat && part_q != '0) begin
      for (int unsigned i = 0; i < DB; i++) axis_out_tkeep[i] = (i < 32'(part_q));
    end
  end

  assign busy            = (state_q != StIdle);
  assign done            = done_q;
  assign pkt_count       = pkt_count_q;
  assign axis_out_tvalid = (state_q == StSend);
  assign axis_out_tlast  = last_beat;
  assign axis_out_tdata  = {(DW / 16){data_q}};

endmodule

// File: tb/tb_packet_gen_prog.sv
// Directed bench for packet_gen_prog: expected beats are queued as each run is launched and
// popped by a monitor on every handshake; stalls are checked for stable payload.
module tb_packet_gen_prog;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0, stop = 1'b0;
  logic [31:0]  num_packets = '0;
  logic [7:0]   gap_cycles = '0;
  logic         pattern_mode = 1'b0;
  logic         cfg_we = 1'b0;
  logic [2:0]   cfg_addr = '0;
  logic [15:0]  cfg_len = '0;
  logic         busy, done;
  logic [31:0]  pkt_count;
  logic [127:0] tdata;
  logic [15:0]  tkeep;
  logic         tlast, tvalid;
  logic         tready = 1'b1;

  packet_gen_prog #(.DW(128), .NUM_LEN(8), .LEN_W(16)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .start           (start),
    .stop            (stop),
    .num_packets     (num_packets),
    .gap_cycles      (gap_cycles),
    .pattern_mode    (pattern_mode),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_len         (cfg_len),
    .busy            (busy),
    .done            (done),
    .pkt_count       (pkt_count),
    .axis_out_tdata  (tdata),
    .axis_out_tkeep  (tkeep),
    .axis_out_tlast  (tlast),
    .axis_out_tvalid (tvalid),
    .axis_out_tready (tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;

  beat_t        exp_q[$];
  int           hs_cyc[$];
  int           cyc = 0;
  int           last_hs = 0;
  int           checks = 0;
  int           errors = 0;
  logic [15:0]  mdata = 16'd1;
  logic         stalled = 1'b0;
  logic [127:0] held_d;
  logic [15:0]  held_k;
  logic         held_l;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queues one packet of len bytes using the bench's own data counter.
  task automatic push_pkt(input int len, input bit restart);
    int    le, nb, p;
    beat_t e;
    le = (len == 0) ? 1 : len;
    nb = (le + 15) / 16;
    p  = le % 16;
    if (restart) mdata = 16'd1;
    for (int b = 1; b <= nb; b++) begin
      e.d = {8{mdata}};
      e.k = (b == nb && p != 0) ? 16'((1 << p) - 1) : 16'hFFFF;
      e.l = (b == nb);
      exp_q.push_back(e);
      mdata = mdata + 16'd1;
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (tvalid) begin
        if (stalled) begin
          chk("hold_tdata", tdata, held_d);
          chk("hold_tkeep", 128'(tkeep), 128'(held_k));
          chk("hold_tlast", 128'(tlast), 128'(held_l));
        end
        if (tready) begin
          hs_cyc.push_back(cyc);
          last_hs = cyc;
          stalled = 1'b0;
          chk("beat_expected", 128'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            beat_t e;
            e = exp_q.pop_front();
            chk("tdata", tdata, e.d);
            chk("tkeep", 128'(tkeep), 128'(e.k));
            chk("tlast", 128'(tlast), 128'(e.l));
          end
        end else begin
          stalled = 1'b1;
          held_d  = tdata;
          held_k  = tkeep;
          held_l  = tlast;
        end
      end else begin
        if (stalled) chk("tvalid_dropped", 128'(tvalid), 1);
        stalled = 1'b0;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input int len);
    step();
    cfg_we   = 1'b1;
    cfg_addr = 3'(addr);
    cfg_len  = 16'(len);
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic run(input int num, input int gap, input bit mode);
    step();
    num_packets  = 32'(num);
    gap_cycles   = 8'(gap);
    pattern_mode = mode;
    hs_cyc.delete();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 128'(done), 1);
    if (done) begin
      chk({tag, "_busy_low"}, 128'(busy), 0);
      chk({tag, "_done_lat"}, 128'(cyc - last_hs), 1);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 128'(done), 0);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 128'(tvalid), 0);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_done", 128'(done), 0);
    chk("rst_pkt_count", 128'(pkt_count), 0);
    step();
    resetn = 1'b1;

    // 18-byte single packet
    cfg_write(0, 18);
    mdata = 16'd1;
    push_pkt(18, 1'b1);
    run(1, 0, 1'b0);
    wait_done("t1", 50);
    chk("t1_pkt_count", 128'(pkt_count), 1);
    chk("t1_queue_empty", 128'(exp_q.size()), 0);

    // Full last beat followed by a zero-length packet with no bubble
    cfg_write(0, 32);
    cfg_write(1, 0);
    push_pkt(32, 1'b1);
    push_pkt(0, 1'b0);
    run(2, 0, 1'b0);
    wait_done("t2", 50);
    chk("t2_pkt_count", 128'(pkt_count), 2);
    chk("t2_queue_empty", 128'(exp_q.size()), 0);
    chk("t2_hs_n", 128'(hs_cyc.size()), 3);
    if (hs_cyc.size() == 3) chk("t2_no_bubble", 128'(hs_cyc[2] - hs_cyc[0]), 2);

    // Gap of 3 cycles, pattern restart each packet
    for (int i = 0; i < 8; i++) cfg_write(i, 16);
    for (int i = 0; i < 3; i++) push_pkt(16, 1'b1);
    run(3, 3, 1'b1);
    wait_done("t3", 80);
    chk("t3_pkt_count", 128'(pkt_count), 3);
    chk("t3_queue_empty", 128'(exp_q.size()), 0);
    chk("t3_hs_n", 128'(hs_cyc.size()), 3);
    if (hs_cyc.size() == 3) begin
      chk("t3_gap_a", 128'(hs_cyc[1] - hs_cyc[0]), 4);
      chk("t3_gap_b", 128'(hs_cyc[2] - hs_cyc[1]), 4);
    end

    // Random backpressure on a 1021-byte packet
    cfg_write(0, 1021);
    push_pkt(1021, 1'b1);
    run(1, 0, 1'b0);
    begin
      int  n;
      bit  seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 2000) begin
        tready = 1'($urandom_range(0, 1));
        @(negedge clk);
        seen = done;
        step();
        n++;
      end
      tready = 1'b1;
      chk("t4_done_seen", 128'(seen), 1);
    end
    chk("t4_pkt_count", 128'(pkt_count), 1);
    chk("t4_beats", 128'(hs_cyc.size()), 64);
    chk("t4_queue_empty", 128'(exp_q.size()), 0);

    // Continuous run, stop on beat 5 of packet 2
    for (int i = 0; i < 8; i++) cfg_write(i, 205);
    push_pkt(205, 1'b1);
    push_pkt(205, 1'b0);
    run(0, 0, 1'b0);
    begin
      int n;
      n = 0;
      while (hs_cyc.size() < 17 && n < 100) begin
        step();
        n++;
      end
      chk("t5_reach_beat", 128'(hs_cyc.size()), 17);
      stop = 1'b1;
      step();
      stop = 1'b0;
    end
    wait_done("t5", 50);
    chk("t5_pkt_count", 128'(pkt_count), 2);
    chk("t5_queue_empty", 128'(exp_q.size()), 0);
    chk("t5_busy", 128'(busy), 0);

    // Asynchronous reset mid-packet
    push_pkt(205, 1'b1);
    run(1, 0, 1'b0);
    begin
      int n;
      n = 0;
      while (hs_cyc.size() < 3 && n < 50) begin
        step();
        n++;
      end
    end
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_async_tvalid", 128'(tvalid), 0);
    chk("t6_async_busy", 128'(busy), 0);
    exp_q.delete();
    step();
    step();
    resetn = 1'b1;
    repeat (4) step();
    chk("t6_idle_tvalid", 128'(tvalid), 0);
    chk("t6_idle_busy", 128'(busy), 0);
    chk("t6_pkt_count", 128'(pkt_count), 0);
    for (int i = 0; i < 8; i++) push_pkt(16, 1'b1);
    run(8, 0, 1'b1);
    wait_done("t6", 60);
    chk("t6_pkt_count_run", 128'(pkt_count), 8);
    chk("t6_queue_empty", 128'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/packet_gen_prog.md
Name: packet_gen_prog

Overview:
Programmable AXI-Stream test-packet generator; parametrised successor to the fixed-table packet generator.
- Packet lengths come from a run-time writable table.
- Configurable packet count (finite or continuous), inter-packet gap, data-pattern mode, graceful stop.
- Sits at the head of packet-header/datapath demo chains as traffic source for downstream framers and FIFOs.

Parameters:
- DW, 128, stream data width in bits; multiple of 16, >=16.
- NUM_LEN, 8, length-table depth; power of 2, >=2.
- LEN_W, 16, packet-length width in bytes.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous, active-low.
- start  in  1  begin a run; sampled only in IDLE.
- stop  in  1  request graceful halt; sampled every cycle.
- num_packets  in  32  packets per run; 0 = continuous. Latched at start.
- gap_cycles  in  8  idle cycles between packets. Latched at start.
- pattern_mode  in  1  0 = data counter free-runs across packets; 1 = counter restarts at 1 each packet. Latched at start.
- cfg_we  in  1  length-table write strobe.
- cfg_addr  in  clog2(NUM_LEN)  table index.
- cfg_len  in  LEN_W  packet length in bytes.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- pkt_count  out  32  packets completed this run; cleared on start.
- axis_out_tdata  out  DW  16-bit data counter replicated DW/16 times.
- axis_out_tkeep  out  DW/8  byte enables.
- axis_out_tlast  out  1  last beat of packet.
- axis_out_tvalid  out  1  beat valid.
- axis_out_tready  in  1  downstream ready.

Behaviour:
- Reset (async, resetn=0):
  - State -> IDLE.
  - tvalid, busy, done = 0 immediately.
  - pkt_count = 0, data counter = 1, table index = 0.
  - Every table entry = DW/8.
- FSM states: IDLE, SEND, GAP.
  - IDLE + start: latch cfg inputs; clear pkt_count; idx = 0; data = 1; latch len = table[0]; beat = 1; -> SEND. First tvalid on the next cycle.
  - SEND: tvalid = 1. On a handshake (tvalid & tready): beat++ and data++.
  - On a tlast handshake:
    - pkt_count++; idx++ (wraps NUM_LEN-1 -> 0).
    - Next state, in priority order:
      - IDLE, if stop was seen since the packet began, or pkt_count reaches num_packets (num_packets != 0).
      - GAP, if gap_cycles != 0.
      - Otherwise stay in SEND with the next packet's first beat on the very next cycle (no bubble).
  - GAP: tvalid = 0 for exactly gap_cycles cycles, then -> SEND. stop during GAP -> IDLE next cycle.
- Packet start: len = table[idx] is latched into a register.
  - A table write in the same cycle as the latch yields the pre-write value.
  - Writes at any other time take effect from the next packet latch; the current packet is never altered.
- Length arithmetic (DB = DW/8):
  - len 0 is treated as 1.
  - beats = ceil(len/DB); partial = len mod DB.
  - tlast = (beat == beats).
  - tkeep = all ones, except on the tlast beat with partial != 0: low `partial` bits set.
- Data counter:
  - 16-bit, wraps 0xFFFF -> 0.
  - pattern_mode = 1 reloads 1 at each packet's first beat.
- AXI rules:
  - tdata, tkeep, tlast are stable while tvalid & !tready.
  - tvalid never drops mid-packet except on reset.
  - No combinational path from tready to tvalid.
- stop:
  - Never truncates a packet.
  - stop in IDLE is ignored.
  - stop and start in the same IDLE cycle: start wins, and the stop is also recorded, so the run ends after one packet.
- done: asserted for 1 cycle in the first IDLE cycle after a run; busy is low that cycle.
- start while busy is ignored.
- cfg writes are legal in every state.

Test Plan:
- DW=128: write table[0] = 18; num_packets=1, gap=0, tready=1; pulse start -> 2 beats; beat 2 tlast=1, tkeep=0x0003; data 0x0001 then 0x0002 replicated; done pulse one cycle after beat 2; pkt_count=1.
- table[0]=32, table[1]=0, num_packets=2, tready=1 -> packet A: 2 beats, last tkeep=0xFFFF. Packet B: 1 beat, tkeep=0x0001, tlast=1, starting on the cycle right after A's tlast.
- gap=3, num_packets=3, all entries 16, pattern_mode=1 -> tvalid low exactly 3 cycles between packets; every beat data=0x0001; pkt_count=3, then done.
- Random tready (50%), table entry 1021 -> 64 beats; final tkeep=0x1FFF; tdata/tkeep/tlast held constant across every stall; no beat lost or duplicated.
- Continuous mode (num_packets=0), all entries 205; assert stop on beat 5 of packet 2 -> packet 2 completes (13 beats, last tkeep=0x1FFF), then IDLE, done pulse, pkt_count=2.
- Drop resetn mid-packet -> tvalid=0 asynchronously; after release stays IDLE until start; table back to all 16.
